// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM block: register map, reset defaults,
// and an elaboration-time helper for sizing the register address bus.
package pwm_pkg;

  localparam int PERIOD_RST_DEF = 999999;

  function automatic int addr_period(input int num_ch);
    return num_ch;
  endfunction

  function automatic int addr_presc(input int num_ch);
    return num_ch + 1;
  endfunction

  function automatic int clog2_int(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler tick, period counter and frame-wrap detection.
// wrap is combinational in the boundary cycle, period_end follows one clk later; never stalls.
module pwm_timebase #(
  parameter int CNT_W   = 20,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [CNT_W-1:0]   period_act,
  input  logic [PRESC_W-1:0] prescale_act,
  output logic [CNT_W-1:0]   cnt,
  output logic               wrap,
  output logic               period_end
);

  logic [PRESC_W-1:0] pre_cnt;
  logic               tick;

  // Active values only change at a wrap or while disabled, when pre_cnt and cnt
  // restart from zero, so an equality compare never gets overrun.
  assign tick = enable && (pre_cnt == prescale_act);
  assign wrap = tick && (cnt == period_act);

  always_ff @(posedge clk) begin
    if (!reset_n || !enable) begin
      pre_cnt    <= '0;
      cnt        <= '0;
      period_end <= 1'b0;
    end else begin
      period_end <= wrap;
      if (tick) begin
        pre_cnt <= '0;
        cnt     <= wrap ? '0 : cnt + 1'b1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM with shared prescaled timebase and double-buffered duty/period/prescale.
// pwm_out lags cnt by one clk; register writes are accepted every cycle with no backpressure.
module pwm_multi_ctrl
  import pwm_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int CNT_W      = 20,
  parameter int PRESC_W    = 8,
  parameter int PERIOD_RST = PERIOD_RST_DEF,
  parameter int ADDR_W     = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] polarity,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_end,
  output logic [CNT_W-1:0]  cnt_out
);

  localparam logic [ADDR_W-1:0] A_PERIOD = ADDR_W'(addr_period(NUM_CH));
  localparam logic [ADDR_W-1:0] A_PRESC  = ADDR_W'(addr_presc(NUM_CH));

  if (ADDR_W < clog2_int(NUM_CH + 2) || NUM_CH < 1 || NUM_CH > 16) begin : g_param_check
    $error("pwm_multi_ctrl: NUM_CH out of range or ADDR_W too narrow for the register map");
  end

  logic [CNT_W-1:0]   period_sh, period_act, cnt;
  logic [PRESC_W-1:0] presc_sh, presc_act;
  logic               wrap, load_act;
  logic [NUM_CH-1:0]  raw;

  // While disabled the active copies follow the shadows so setup writes apply at once.
  assign load_act = wrap || !enable;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      period_sh  <= CNT_W'(PERIOD_RST);
      period_act <= CNT_W'(PERIOD_RST);
      presc_sh   <= '0;
      presc_act  <= '0;
    end else begin
      if (wr_en && wr_addr == A_PERIOD) period_sh <= wr_data;
      if (wr_en && wr_addr == A_PRESC)  presc_sh  <= wr_data[PRESC_W-1:0];
      if (load_act) begin
        period_act <= period_sh;
        presc_act  <= presc_sh;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] duty_sh, duty_act;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        duty_sh  <= '0;
        duty_act <= '0;
      end else begin
        if (wr_en && wr_addr == ADDR_W'(i)) duty_sh <= wr_data;
        if (load_act) duty_act <= duty_sh;
      end
    end

    assign raw[i] = (cnt < duty_act);
  end

  pwm_timebase #(
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .period_act   (period_act),
    .prescale_act (presc_act),
    .cnt          (cnt),
    .wrap         (wrap),
    .period_end   (period_end)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pwm_out <= polarity;
    end else begin
      pwm_out <= enable ? (raw ^ polarity) : polarity;
    end
  end

  assign cnt_out = cnt;

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Bench for pwm_multi_ctrl: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a frame-position reference model.
module tb_pwm_multi_ctrl;

  localparam int NUM_CH     = 8;
  localparam int CNT_W      = 20;
  localparam int PRESC_W    = 8;
  localparam int ADDR_W     = 5;
  localparam int PERIOD_RST = 999999;

  logic              clk = 1'b0;
  logic              reset_n, enable, wr_en;
  logic [NUM_CH-1:0] polarity, pwm_out;
  logic [ADDR_W-1:0] wr_addr;
  logic [CNT_W-1:0]  wr_data, cnt_out;
  logic              period_end;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  pwm_multi_ctrl #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .PRESC_W    (PRESC_W),
    .PERIOD_RST (PERIOD_RST),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .polarity   (polarity),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .pwm_out    (pwm_out),
    .period_end (period_end),
    .cnt_out    (cnt_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: tracks the clock position inside the current frame and
  // derives the counter value and duty comparison arithmetically from it.
  longint            sh_duty [NUM_CH];
  longint            ac_duty [NUM_CH];
  longint            sh_per, ac_per, sh_pre, ac_pre, pos, exp_cnt;
  logic [NUM_CH-1:0] exp_pwm;
  logic              exp_pend;

  always @(posedge clk) begin
    bit     load;
    longint c;
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sh_duty[i] = 0;
        ac_duty[i] = 0;
      end
      sh_per = PERIOD_RST; ac_per = PERIOD_RST;
      sh_pre = 0;          ac_pre = 0;
      pos = 0;
      exp_pwm  = polarity;
      exp_pend = 1'b0;
    end else begin
      load = 1'b0;
      if (!enable) begin
        pos      = 0;
        exp_pend = 1'b0;
        exp_pwm  = polarity;
        load     = 1'b1;
      end else begin
        c = pos / (ac_pre + 1);
        for (int i = 0; i < NUM_CH; i++) exp_pwm[i] = (c < ac_duty[i]) ^ polarity[i];
        exp_pend = (pos == (ac_per + 1) * (ac_pre + 1) - 1);
        pos      = exp_pend ? 0 : pos + 1;
        load     = exp_pend;
      end
      if (load) begin
        for (int i = 0; i < NUM_CH; i++) ac_duty[i] = sh_duty[i];
        ac_per = sh_per;
        ac_pre = sh_pre;
      end
      if (wr_en) begin
        if (wr_addr < NUM_CH)            sh_duty[wr_addr] = wr_data;
        else if (wr_addr == NUM_CH)      sh_per = wr_data;
        else if (wr_addr == NUM_CH + 1)  sh_pre = wr_data % 256;
      end
    end
    exp_cnt = pos / (ac_pre + 1);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check_eq("pwm_out", pwm_out, exp_pwm);
      check_eq("period_end", period_end, exp_pend);
      check_eq("cnt_out", cnt_out, exp_cnt);
    end
  end

  task automatic wr(input int addr, input int data);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(addr);
    wr_data = CNT_W'(data);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_pend(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_end !== 1'b1 && n < 5000);
    if (period_end !== 1'b1) check_eq("pend_timeout", 0, 1);
  endtask

  task automatic wait_cnt(input int v);
    int k;
    k = 0;
    while (cnt_out !== CNT_W'(v) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (cnt_out !== CNT_W'(v)) check_eq("cnt_timeout", cnt_out, v);
  endtask

  int                hi_cnt [NUM_CH];
  logic [NUM_CH-1:0] first_smp;

  task automatic count_highs(input int n);
    for (int ch = 0; ch < NUM_CH; ch++) hi_cnt[ch] = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) first_smp = pwm_out;
      for (int ch = 0; ch < NUM_CH; ch++) hi_cnt[ch] += int'(pwm_out[ch]);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n;
    reset_n = 1'b0; enable = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; polarity = 8'h50;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    check_eq("rst_cnt", cnt_out, 0);
    check_eq("rst_pwm", pwm_out, 8'h50);
    check_eq("rst_pend", period_end, 0);
    reset_n = 1'b1;

    // Basic duty set up while disabled
    polarity = '0;
    wr(NUM_CH, 9); wr(NUM_CH + 1, 0); wr(0, 3);
    enable = 1'b1;
    wait_pend(n); wait_pend(n);
    check_eq("basic_spacing", n, 10);
    count_highs(10);
    check_eq("basic_high0", hi_cnt[0], 3);

    // Shadow update mid-frame, then a write landing on the wrap edge
    wait_cnt(2); wr(0, 7);
    wait_pend(n); count_highs(10);
    check_eq("shadow_high0", hi_cnt[0], 7);
    wait_cnt(9); wr(0, 5);
    count_highs(10);
    check_eq("wrapwr_old", hi_cnt[0], 7);
    count_highs(10);
    check_eq("wrapwr_new", hi_cnt[0], 5);

    // Duty boundaries and period 0
    enable = 1'b0;
    wr(1, 0); wr(2, 10); wr(3, 50);
    enable = 1'b1;
    wait_pend(n); count_highs(30);
    check_eq("duty0_const", hi_cnt[1], 0);
    check_eq("duty_p1_const", hi_cnt[2], 30);
    check_eq("duty_big_const", hi_cnt[3], 30);
    enable = 1'b0;
    wr(NUM_CH, 0);
    enable = 1'b1;
    wait_pend(n); wait_pend(n);
    check_eq("per0_spacing", n, 1);

    // Prescaler with inverted channel 0
    enable = 1'b0; polarity = 8'h01;
    wr(NUM_CH + 1, 3); wr(NUM_CH, 4); wr(0, 2);
    enable = 1'b1;
    wait_pend(n); wait_pend(n);
    check_eq("presc_spacing", n, 20);
    count_highs(20);
    check_eq("presc_high0", hi_cnt[0], 12);
    enable = 1'b0;
    @(negedge clk);
    check_eq("dis_pwm", pwm_out, 8'h01);

    // Reset mid-frame, then an out-of-range write
    enable = 1'b1;
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_cnt", cnt_out, 0);
    check_eq("midrst_pwm", pwm_out, 8'h01);
    reset_n = 1'b1;
    enable = 1'b0;
    wr(NUM_CH + 2, 3); wr(NUM_CH, 7);
    enable = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("illegal_pwm", pwm_out, 8'h01);

    // All channels, duty[i] = i over an 8-clk frame
    enable = 1'b0; polarity = '0;
    for (int i = 0; i < NUM_CH; i++) wr(i, i);
    enable = 1'b1;
    wait_pend(n); count_highs(8);
    for (int ch = 0; ch < NUM_CH; ch++) check_eq($sformatf("multi_high%0d", ch), hi_cnt[ch], ch);
    check_eq("multi_align", first_smp, 8'hFE);

    // Randomized traffic, checked cycle by cycle against the model
    for (int k = 0; k < 2500; k++) begin
      wr_en   = ($urandom_range(0, 5) == 0);
      wr_addr = ADDR_W'($urandom_range(0, 31));
      if (wr_addr < NUM_CH)           wr_data = CNT_W'($urandom_range(0, 25));
      else if (wr_addr == NUM_CH)     wr_data = CNT_W'($urandom_range(0, 20));
      else if (wr_addr == NUM_CH + 1) wr_data = CNT_W'($urandom_range(0, 3) + 256 * $urandom_range(0, 1));
      else                            wr_data = CNT_W'($urandom);
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      if ($urandom_range(0, 49) == 0) polarity = NUM_CH'($urandom);
      reset_n = ($urandom_range(0, 599) != 0);
      if (!reset_n) enable = 1'b0;
      @(negedge clk);
    end
    wr_en = 1'b0; reset_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_multi_ctrl.md
Name: pwm_multi_ctrl

Overview:
- Multi-channel PWM generator for servo/ESC drive.
- Successor to the single-duty PWM export path: NUM_CH channels share one prescaled timebase, with per-channel duty and output polarity.
- Writes land in double-buffered shadow registers and take effect only at a period boundary, giving glitch-free updates.
- Sits between the soft-CPU register bus (simple write strobe) and the board PWM pins.

Parameters:
- NUM_CH, 8, number of PWM channels (1..16).
- CNT_W, 20, width of period/duty counters (20 bits = 1M clocks, covers a 20 ms servo frame at 50 MHz).
- PRESC_W, 8, width of the clock prescaler.
- PERIOD_RST, 999999, period value loaded at reset.
- ADDR_W, 5, register address width; must satisfy 2^ADDR_W >= NUM_CH+2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset, sampled on rising clk.
- enable  in  1  1 = run; 0 = hold counters at 0 and drive idle levels.
- polarity  in  NUM_CH  per-channel output inversion (1 = active-low).
- wr_en  in  1  register write strobe, one cycle per write.
- wr_addr  in  ADDR_W  address 0..NUM_CH-1 = duty[i]; NUM_CH = period; NUM_CH+1 = prescale.
- wr_data  in  CNT_W  write data; prescale uses bits [PRESC_W-1:0].
- pwm_out  out  NUM_CH  registered PWM outputs.
- period_end  out  1  one-clk pulse at each period wrap.
- cnt_out  out  CNT_W  current period counter, for debug/readback.

Behaviour:
- Reset (reset_n=0 at rising clk):
  - shadow and active duty = 0; shadow and active period = PERIOD_RST; shadow and active prescale = 0.
  - prescale counter = 0, cnt = 0, period_end = 0, pwm_out = polarity (sampled).
  - Reset mid-period aborts the frame immediately; no partial pulse completes.
- Register writes:
  - When wr_en=1, wr_data is written into the shadow register at wr_addr on that edge.
  - Writes to addresses >= NUM_CH+2 are ignored.
  - Writes never alter active registers directly, except while enable=0.
- Prescaler:
  - pre_cnt counts 0..prescale_act; tick=1 in the cycle pre_cnt==prescale_act, then pre_cnt returns to 0.
  - prescale_act=0 gives tick every clk.
- Period counter:
  - On tick, cnt increments; when cnt==period_act on a tick, cnt<=0.
  - The frame therefore lasts (period_act+1)*(prescale_act+1) clks.
  - period_act=0: cnt stays 0; each tick is a wrap.
- Boundary (tick and cnt==period_act):
  - period_end<=1 for exactly one clk.
  - All active registers <= shadow registers on the same edge, so the next frame starts with the new values.
- Simultaneous write and boundary: the boundary loads the pre-write shadow value; the new write is applied at the following boundary.
- Output:
  - raw[i] = (cnt < duty_act[i]) and pwm_out[i] <= enable ? raw[i]^polarity[i] : polarity[i], which is one clk of latency from cnt.
  - duty_act=0: constant inactive.
  - duty_act > period_act: constant active, with no glitch at the wrap.
- enable=0:
  - pre_cnt and cnt are held at 0; period_end=0.
  - Active registers track shadows every cycle, so a write takes effect immediately.
  - On enable 0->1, the first frame starts at cnt=0 with the current values.
  - First active output appears 1 clk after enable rises.
- polarity changes are applied combinationally to the next registered output, with no boundary wait.
- cnt_out = cnt, unregistered copy.

Decomposition:
- Package pwm_pkg holds:
  - address constants ADDR_PERIOD(NUM_CH) and ADDR_PRESC(NUM_CH+1), as functions of NUM_CH;
  - the default PERIOD_RST;
  - a clog2 helper for ADDR_W checking.
- Sub-module pwm_timebase (prescaler, period counter, tick, wrap/period_end generation, enable hold) is instantiated once.
- Channel comparators and shadow/active registers are a generate loop in the top.

Test Plan:
- Basic duty, disabled setup:
  - Stimulus: reset, enable=0, write period=9, prescale=0, duty[0]=3, then enable=1.
  - Response: pwm_out[0] high 3 clks, low 7 clks, repeating; period_end pulses every 10 clks.
- Shadow update:
  - Stimulus: running with period=9, write duty[0]=7 at cnt=2.
  - Response: current frame stays 3 high; the next frame after period_end is 7 high / 3 low.
  - Stimulus: a write landing on the wrap cycle.
  - Response: the new value is deferred one extra frame.
- Boundaries:
  - Stimulus: duty[1]=0, duty[2]=10, duty[3]=50, period=9.
  - Response: ch1 constant 0; ch2 and ch3 constant 1 with no glitch across wraps.
  - Stimulus: period=0.
  - Response: period_end every tick.
- Prescaler and polarity:
  - Stimulus: prescale=3, period=4, duty[0]=2, polarity[0]=1.
  - Response: frame = 20 clks; pwm_out[0] low 8 clks, high 12 clks.
  - Stimulus: enable=0.
  - Response: pwm_out = polarity.
- Reset and illegal address:
  - Stimulus: assert reset_n=0 mid-frame.
  - Response: on the next edge cnt=0, pwm_out=polarity, period back to PERIOD_RST, duties 0.
  - Stimulus: write to addr NUM_CH+2.
  - Response: no register changes.
- Multi-channel:
  - Stimulus: NUM_CH=8, duty[i]=i, period=7.
  - Response: channel i is high exactly i clks per 8-clk frame, and all rising edges align at frame start.
